// File: rtl/alu_pkg.sv
// Shared opcode constants, opcode classification helpers and FSM state type
// for the shared ALU controller.
package alu_pkg;

  localparam logic [3:0] OPE_ADD  = 4'b0000;
  localparam logic [3:0] OPE_SUB  = 4'b0101;
  localparam logic [3:0] OPE_SLT  = 4'b0110;
  localparam logic [3:0] OPE_AND  = 4'b0001;
  localparam logic [3:0] OPE_SLTU = 4'b0100;
  localparam logic [3:0] OPE_XOR  = 4'b0010;
  localparam logic [3:0] OPE_OR   = 4'b0011;
  localparam logic [3:0] OPE_SLL  = 4'b1001;
  localparam logic [3:0] OPE_SRL  = 4'b1010;
  localparam logic [3:0] OPE_SRA  = 4'b1000;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic is_legal_ope(input logic [3:0] ope);
    logic legal;
    case (ope)
      OPE_ADD, OPE_SUB, OPE_SLT, OPE_AND, OPE_SLTU,
      OPE_XOR, OPE_OR, OPE_SLL, OPE_SRL, OPE_SRA: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic is_shift_ope(input logic [3:0] ope);
    return ope[3];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx,
  output logic            any
);

  // Scan offsets from ptr outward; the first hit locks out later candidates
  always_comb begin
    logic hit;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    hit   = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      for (int k = 0; k < NREQ; k++) begin
        hit      = req[k] && !any && (((int'(ptr) + off) % NREQ) == k);
        grant[k] = grant[k] | hit;
        idx      = hit ? PW'(k) : idx;
        any      = any | hit;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between NREQ requesters: round-robin grant,
// operand capture, one-cycle execute, then a held response until accepted.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NREQ-1:0]   req_valid_i,
  output logic [NREQ-1:0]   req_ready_o,
  input  logic [4*NREQ-1:0] req_ope_i,
  input  logic [DW*NREQ-1:0] req_a_i,
  input  logic [DW*NREQ-1:0] req_b_i,
  output logic [NREQ-1:0]   rsp_valid_o,
  input  logic [NREQ-1:0]   rsp_ready_i,
  output logic [DW-1:0]     rsp_data_o,
  output logic              rsp_err_o,
  output logic [DW-1:0]     alu_a_o,
  output logic [DW-1:0]     alu_b_o,
  output logic [3:0]        alu_ope_o,
  output logic              alu_sel_o,
  input  logic [DW-1:0]     alu_c_i,
  output logic              busy_o
);

  localparam int PW = $clog2(NREQ);

  state_e          state_r, state_s;
  logic [PW-1:0]   rr_ptr_r, gnt_idx_s, ptr_nxt_s;
  logic [NREQ-1:0] grant_s, gnt_oh_r, rsp_valid_r;
  logic            any_s, take_s, done_s;
  logic [DW-1:0]   a_r, b_r, data_r, cap_a_s, cap_b_s;
  logic [3:0]      ope_r, cap_ope_s;
  logic            sel_r, err_r;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (req_valid_i),
    .ptr   (rr_ptr_r),
    .grant (grant_s),
    .idx   (gnt_idx_s),
    .any   (any_s)
  );

  // Select the granted requester's operands with a one-hot AND-OR mux
  always_comb begin
    cap_a_s   = '0;
    cap_b_s   = '0;
    cap_ope_s = 4'b0000;
    for (int k = 0; k < NREQ; k++) begin
      cap_a_s   = cap_a_s   | (req_a_i[k*DW +: DW] & {DW{grant_s[k]}});
      cap_b_s   = cap_b_s   | (req_b_i[k*DW +: DW] & {DW{grant_s[k]}});
      cap_ope_s = cap_ope_s | (req_ope_i[k*4 +: 4] & {4{grant_s[k]}});
    end
  end

  // Pointer advances to the requester after the winner, wrapping at NREQ
  always_comb begin
    if (gnt_idx_s == PW'(NREQ - 1)) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = gnt_idx_s + PW'(1);
    end
  end

  // Next-state logic and handshake strobes
  always_comb begin
    state_s = state_r;
    take_s  = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      IDLE: begin
        take_s  = any_s;
        state_s = any_s ? EXEC : IDLE;
      end
      EXEC: state_s = RESP;
      RESP: begin
        // Only the winner's rsp_ready bit can complete the handshake
        done_s  = |(rsp_ready_i & rsp_valid_r);
        state_s = done_s ? IDLE : RESP;
      end
      default: state_s = IDLE;
    endcase
  end

  // State, capture registers and response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      rr_ptr_r    <= '0;
      gnt_oh_r    <= '0;
      rsp_valid_r <= '0;
      a_r         <= '0;
      b_r         <= '0;
      ope_r       <= 4'b0000;
      sel_r       <= 1'b0;
      data_r      <= '0;
      err_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      if (take_s) begin
        a_r      <= cap_a_s;
        b_r      <= cap_b_s;
        ope_r    <= cap_ope_s;
        sel_r    <= is_shift_ope(cap_ope_s);
        gnt_oh_r <= grant_s;
        rr_ptr_r <= ptr_nxt_s;
      end
      if (state_r == EXEC) begin
        data_r      <= is_legal_ope(ope_r) ? alu_c_i : '0;
        err_r       <= !is_legal_ope(ope_r);
        rsp_valid_r <= gnt_oh_r;
      end else if (done_s) begin
        rsp_valid_r <= '0;
      end
    end
  end

  // Grant is combinational in IDLE; forced low while reset is held
  always_comb begin
    if ((state_r == IDLE) && rst_ni) begin
      req_ready_o = grant_s;
    end else begin
      req_ready_o = '0;
    end
  end

  assign rsp_valid_o = rsp_valid_r;
  assign rsp_data_o  = data_r;
  assign rsp_err_o   = err_r;
  assign alu_a_o     = a_r;
  assign alu_b_o     = b_r;
  assign alu_ope_o   = ope_r;
  assign alu_sel_o   = sel_r;
  assign busy_o      = (state_r != IDLE);

endmodule
